ps2_receiver: RTL

Device-side PS/2 receiver for the DE-series top level. It takes the raw `ps2_clk`/`ps2_dat` lines driven by the simulated keyboard interface, filters and frames the 11-bit PS/2 packets, and checks parity and stop bit. It decodes the `E0`/`F0` prefixes and delivers one qualified scan-code event per key make or break to downstream logic (HEX/LEDR display, game FSMs).

---
 rtl/ps2_pkg.sv | 14 +
 rtl/ps2_line_filter.sv | 46 ++++
 rtl/ps2_receiver.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stability filter; the output only
// follows the line after FILTER_LEN identical consecutive samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic filt_o
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q holds how many consecutive samples have disagreed with filt_q
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1))
                filt_d = sync2_q;
            else
                cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-side receiver: filters both lines, frames 11-bit packets,
// checks parity/stop, and folds E0/F0 prefixes into one event per key.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic [7:0] raw_byte,
    output logic       raw_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_f, dat_f, fall;
    logic clk_prev_q;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic          pend_ext_q, pend_ext_d;
    logic          pend_brk_q, pend_brk_d;
    logic [7:0]    scan_q, scan_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [7:0]    raw_q, raw_d;
    logic          raw_vld_q, raw_vld_d;
    logic          code_vld_q, code_vld_d;
    logic          par_err_q, par_err_d;
    logic          frm_err_q, frm_err_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .line_i (ps2_clk),
        .filt_o (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .line_i (ps2_dat),
        .filt_o (dat_f)
    );

    assign fall = clk_prev_q & ~clk_f;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_d       = to_q;
        pend_ext_d = pend_ext_q;
        pend_brk_d = pend_brk_q;
        scan_d     = scan_q;
        brk_d      = brk_q;
        ext_d      = ext_q;
        raw_d      = raw_q;
        raw_vld_d  = 1'b0;
        code_vld_d = 1'b0;
        par_err_d  = 1'b0;
        frm_err_d  = 1'b0;

        if (state_q == IDLE || fall)
            to_d = '0;
        else
            to_d = to_q + TW'(1);

        case (state_q)
            IDLE: begin
                if (fall && !dat_f) begin
                    state_d  = DATA;
                    bitcnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d  = {dat_f, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7)
                        state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat_f;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (!dat_f) begin
                        frm_err_d  = 1'b1;
                        pend_ext_d = 1'b0;
                        pend_brk_d = 1'b0;
                    end else if (^{shift_q, par_q} == 1'b0) begin
                        par_err_d  = 1'b1;
                        pend_ext_d = 1'b0;
                        pend_brk_d = 1'b0;
                    end else begin
                        raw_vld_d = 1'b1;
                        raw_d     = shift_q;
                        if (shift_q == PS2_EXT) begin
                            pend_ext_d = 1'b1;
                        end else if (shift_q == PS2_BRK) begin
                            pend_brk_d = 1'b1;
                        end else begin
                            scan_d     = shift_q;
                            brk_d      = pend_brk_q;
                            ext_d      = pend_ext_q;
                            code_vld_d = 1'b1;
                            pend_ext_d = 1'b0;
                            pend_brk_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A fall event in the same cycle restarts the window, so it wins
        if (state_q != IDLE && !fall && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d    = IDLE;
            frm_err_d  = 1'b1;
            pend_ext_d = 1'b0;
            pend_brk_d = 1'b0;
            to_d       = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_prev_q <= 1'b1;
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            to_q       <= '0;
            pend_ext_q <= 1'b0;
            pend_brk_q <= 1'b0;
            scan_q     <= 8'h00;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            raw_q      <= 8'h00;
            raw_vld_q  <= 1'b0;
            code_vld_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            clk_prev_q <= clk_f;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_q       <= to_d;
            pend_ext_q <= pend_ext_d;
            pend_brk_q <= pend_brk_d;
            scan_q     <= scan_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            raw_q      <= raw_d;
            raw_vld_q  <= raw_vld_d;
            code_vld_q <= code_vld_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign scan_code   = scan_q;
    assign code_valid  = code_vld_q;
    assign is_break    = brk_q;
    assign is_extended = ext_q;
    assign raw_byte    = raw_q;
    assign raw_valid   = raw_vld_q;
    assign parity_err  = par_err_q;
    assign frame_err   = frm_err_q;
    assign busy        = (state_q != IDLE);

endmodule
